// File: rtl/gzip_pkg.sv
// Shared GZIP definitions: output framer state encoding, core word width and
// a buffer fill helper.
package gzip_pkg;

  localparam int GZIP_WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_FLUSH,
    ST_LAST,
    ST_FINISH
  } framer_state_e;

  // Words held plus the word still in the FIFO read pipe.
  function automatic logic [2:0] fill_level(input logic [1:0] occ, input logic infl);
    return {1'b0, occ} + {2'b00, infl};
  endfunction

endpackage

// File: rtl/gzip_out_framer_if.sv
// FIFO read port and host stream channel of the GZIP output framer.
interface gzip_out_framer_if
  import gzip_pkg::*;
#(
  parameter int DATA_WIDTH = GZIP_WORD_W
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rden;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_eof;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rden, m_data, m_valid, m_eof
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rden, m_data, m_valid, m_eof
  );

endinterface

// File: rtl/out_framer_buf.sv
// Three-entry register FIFO between the core FIFO read pipe and the host stream;
// reports its occupancy so the framer can hold back the newest word.
module out_framer_buf
  import gzip_pkg::*;
#(
  parameter int DATA_WIDTH = GZIP_WORD_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] mem [3];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [1:0]            cnt;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // NOTE: non-blocking assignments for every flop so all state updates see the
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; cnt governs which entries are live,
  // and the top masks m_data whenever nothing valid is presented.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
  assign occ  = cnt;

endmodule

// File: rtl/gzip_out_framer.sv
// Drains the GZIP core output FIFO into a valid/ready stream and tags the final
// word of each compressed stream with m_eof. Optional macro: OUT_FRAMER_WCNT_EN.
module gzip_out_framer
  import gzip_pkg::*;
#(
  parameter int DATA_WIDTH   = GZIP_WORD_W,
  parameter int CNT_WIDTH    = 24,
  parameter int EMPTY_SETTLE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 gzip_done,
  gzip_out_framer_if.master    bus,
  output logic [CNT_WIDTH-1:0] word_count
);

  localparam logic [3:0] SETTLE_LAST = 4'(EMPTY_SETTLE - 1);

  framer_state_e         state_q, state_d;
  logic [3:0]            settle_q, settle_d;
  logic                  infl_q;
  logic                  rd_en;
  logic                  read_ok;
  logic                  valid;
  logic                  eof;
  logic                  xfer;
  logic                  pop;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      settle_q <= 4'd0;
      infl_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      infl_q   <= rd_en;
    end
  end

  // Reads are gated by rst_n so the strobe stays low throughout reset.
  assign read_ok = rst_n && !bus.fifo_empty && (fill_level(occ, infl_q) < 3'd3);

  // NOTE: every output of this block gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    rd_en    = 1'b0;
    valid    = 1'b0;
    eof      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rd_en = read_ok;
        if (!bus.fifo_empty) begin
          state_d = ST_STREAM;
        end else if (gzip_done) begin
          state_d  = ST_FLUSH;
          settle_d = 4'd0;
        end
      end
      ST_STREAM: begin
        rd_en = read_ok;
        valid = (occ >= 2'd2);
        if (gzip_done) begin
          state_d  = ST_FLUSH;
          settle_d = 4'd0;
        end
      end
      ST_FLUSH: begin
        rd_en = read_ok;
        valid = (occ >= 2'd2);
        if (!bus.fifo_empty) begin
          settle_d = 4'd0;
        end else if (!infl_q) begin
          // Last empty cycle is also the one with no read issued, so nothing
          // can still be in flight when LAST starts.
          if (settle_q == SETTLE_LAST) begin
            state_d  = ST_LAST;
            settle_d = 4'd0;
          end else begin
            settle_d = settle_q + 4'd1;
          end
        end
      end
      ST_LAST: begin
        // occ==0 here only for a zero-word stream: a single empty eof beat.
        valid = 1'b1;
        eof   = (occ <= 2'd1);
        if (bus.m_ready && eof) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        if (!gzip_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign xfer = valid && bus.m_ready;
  assign pop  = xfer && (occ != 2'd0);

  out_framer_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (infl_q),
    .push_data (bus.fifo_data),
    .pop       (pop),
    .head      (head),
    .occ       (occ)
  );

  assign bus.fifo_rden = rd_en;
  assign bus.m_valid   = valid;
  assign bus.m_eof     = eof;
  assign bus.m_data    = (valid && occ != 2'd0) ? head : '0;

`ifdef OUT_FRAMER_WCNT_EN
  logic [CNT_WIDTH-1:0] wcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q <= '0;
    end else if (state_q == ST_FINISH && !gzip_done) begin
      wcnt_q <= '0;
    end else if (xfer && wcnt_q != '1) begin
      wcnt_q <= wcnt_q + 1'b1;
    end
  end

  assign word_count = wcnt_q;
`else
  assign word_count = '0;
`endif

endmodule

// File: tb/tb_gzip_out_framer.sv
// Directed bench for gzip_out_framer: a queue models the core FIFO, and a
// scoreboard of expected beats is filled as words are queued.
module tb_gzip_out_framer;

  localparam int DW           = 32;
  localparam int CW           = 24;
  localparam int EMPTY_SETTLE = 4;

`ifdef OUT_FRAMER_WCNT_EN
  localparam bit WCNT = 1'b1;
`else
  localparam bit WCNT = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic          eof;
    logic          from_fifo;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          gzip_done;
  logic [CW-1:0] word_count;

  gzip_out_framer_if #(.DATA_WIDTH(DW)) bus ();

  gzip_out_framer #(
    .DATA_WIDTH   (DW),
    .CNT_WIDTH    (CW),
    .EMPTY_SETTLE (EMPTY_SETTLE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gzip_done  (gzip_done),
    .bus        (bus),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] core_q [$];
  exp_t          exp_q  [$];
  int            checks      = 0;
  int            errors      = 0;
  int            ready_mode  = 0;
  int            outstanding = 0;
  int            empty_run   = 0;
  logic          last_rd     = 1'b0;
  logic          last_valid  = 1'b0;
  logic          prev_stall  = 1'b0;
  logic [DW-1:0] prev_data   = '0;
  logic          prev_eof    = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] exp_wc(input int n);
    return WCNT ? CW'(n) : '0;
  endfunction

  task automatic add_word(input logic [DW-1:0] w, input logic last);
    core_q.push_back(w);
    exp_q.push_back('{data: w, eof: last, from_fifo: 1'b1});
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " rden"},  bus.fifo_rden, 0);
    chk({tag, " valid"}, bus.m_valid,   0);
    chk({tag, " eof"},   bus.m_eof,     0);
    chk({tag, " data"},  bus.m_data,    0);
    chk({tag, " wcnt"},  word_count,    0);
  endtask

  // One clock: drive at negedge, sample 1 ns later, bookkeep 1 ns after posedge.
  task automatic cycle();
    exp_t e;
    logic beat;
    logic rd;
    logic pop_fifo;
    beat     = 1'b0;
    rd       = 1'b0;
    pop_fifo = 1'b0;
    @(negedge clk);
    bus.fifo_empty = (core_q.size() == 0);
    case (ready_mode)
      1:       bus.m_ready = !bus.m_ready;
      2:       bus.m_ready = 1'b0;
      default: bus.m_ready = 1'b1;
    endcase
    #1;
    if (rst_n) begin
      if (prev_stall) begin
        chk("stall valid held", bus.m_valid, 1);
        chk("stall data held",  bus.m_data,  prev_data);
        chk("stall eof held",   bus.m_eof,   prev_eof);
      end
      if (bus.fifo_empty) chk("rden while empty", bus.fifo_rden, 0);
      if (outstanding >= 3) chk("rden while buffer full", bus.fifo_rden, 0);
      beat = bus.m_valid && bus.m_ready;
      if (beat) begin
        if (exp_q.size() == 0) begin
          chk("unexpected beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat data", bus.m_data, e.data);
          chk("beat eof",  bus.m_eof,  e.eof);
          pop_fifo = e.from_fifo;
        end
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_eof   = bus.m_eof;
      last_valid = bus.m_valid;
      rd         = bus.fifo_rden;
      if (!bus.fifo_empty)  empty_run = 0;
      else if (!last_rd)    empty_run++;
    end
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (rd && core_q.size() > 0) begin
        bus.fifo_data = core_q.pop_front();
        outstanding++;
      end
      if (pop_fifo) outstanding--;
      last_rd = rd;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, " drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int n;
    rst_n          = 1'b0;
    gzip_done      = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = '0;
    bus.m_ready    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: five words, sink always ready.
    for (int i = 0; i < 5; i++) add_word(32'hA000_0000 + DW'(i), i == 4);
    ready_mode = 0;
    gzip_done  = 1'b1;
    drain("t1", 200);
    chk("t1 word_count", word_count, exp_wc(5));
    gzip_done = 1'b0;
    cycle();
    chk("t1 word_count cleared", word_count, 0);

    // 2: same stream with a toggling sink.
    for (int i = 0; i < 5; i++) add_word(32'hA000_0000 + DW'(i), i == 4);
    ready_mode = 1;
    gzip_done  = 1'b1;
    drain("t2", 300);
    chk("t2 word_count", word_count, exp_wc(5));
    gzip_done  = 1'b0;
    ready_mode = 0;
    cycle();

    // 3: zero-word stream; beat appears 1+EMPTY_SETTLE cycles after done.
    exp_q.push_back('{data: '0, eof: 1'b1, from_fifo: 1'b0});
    gzip_done = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_valid && n < 50);
    chk("t3 eof latency", n - 1, EMPTY_SETTLE + 1);
    chk("t3 beat taken", exp_q.size(), 0);
    chk("t3 word_count", word_count, exp_wc(1));
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3 finish quiet", last_valid, 0);
    end
    gzip_done = 1'b0;
    cycle();

    // 4: empty gap one cycle short of the settle limit, then a late word.
    add_word(32'hB000_0000, 1'b0);
    add_word(32'hB000_0001, 1'b0);
    gzip_done = 1'b1;
    empty_run = 0;
    n = 0;
    while (empty_run < EMPTY_SETTLE - 1 && n < 100) begin
      cycle();
      n++;
    end
    chk("t4 newest word held back", exp_q.size(), 1);
    add_word(32'hB000_0002, 1'b1);
    drain("t4", 200);
    chk("t4 word_count", word_count, exp_wc(3));
    gzip_done = 1'b0;
    cycle();

    // 5: stalled sink fills the buffer, then reset mid-stream.
    for (int i = 0; i < 5; i++) add_word(32'hD000_0000 + DW'(i), i == 4);
    ready_mode = 2;
    repeat (8) cycle();
    chk("t5 buffer full", outstanding, 3);
    chk("t5 head presented", bus.m_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t5 async reset");
    core_q.delete();
    exp_q.delete();
    outstanding    = 0;
    last_rd        = 1'b0;
    prev_stall     = 1'b0;
    bus.fifo_data  = '0;
    bus.fifo_empty = 1'b1;
    ready_mode     = 0;
    @(negedge clk);
    rst_n = 1'b1;
    add_word(32'hE000_0000, 1'b0);
    add_word(32'hE000_0001, 1'b1);
    gzip_done = 1'b1;
    drain("t5 fresh", 200);
    chk("t5 word_count", word_count, exp_wc(2));

    // 6: FINISH holds off the next stream until done drops.
    for (int i = 0; i < 3; i++) add_word(32'hC000_0000 + DW'(i), i == 2);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t6 finish no valid", last_valid, 0);
      chk("t6 finish no read", last_rd, 0);
    end
    gzip_done = 1'b0;
    cycle();
    chk("t6 word_count cleared", word_count, 0);
    gzip_done = 1'b1;
    drain("t6", 200);
    chk("t6 word_count", word_count, exp_wc(3));
    gzip_done = 1'b0;
    repeat (2) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
